cpu_sequencer: RTL

Fetch/execute sequencer for the 8-bit teaching CPU. Replaces the free-running sm flip-flop with a run/stop/single-step state machine. Decodes ir[7:4]/ir[3:0] into the one-hot instruction lines consumed by the control-signal logic. Counts retired instructions and gates every architectural write through cyc_valid.

---
 rtl/cpu_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Fetch/execute sequencer for the 8-bit teaching CPU. Runs a
//               run/stop/single-step state machine, decodes the instruction
//               register into one-hot instruction lines, counts retired
//               instructions and qualifies architectural writes (cyc_valid).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ir,
    input  logic             start,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             step,
    output logic             sm,
    output logic             cyc_valid,
    output logic [16:0]      op,
    output logic [2:0]       state,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    // State encoding
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_PAUSE  = 3'd3;
    localparam logic [2:0] c_HALTED = 3'd4;

    // One-hot instruction line positions
    localparam int c_OP_MOVA    = 0;
    localparam int c_OP_MOVB    = 1;
    localparam int c_OP_MOVC    = 2;
    localparam int c_OP_ADD     = 3;
    localparam int c_OP_SUB     = 4;
    localparam int c_OP_AND1    = 5;
    localparam int c_OP_NOT1    = 6;
    localparam int c_OP_RSR     = 7;
    localparam int c_OP_RSL     = 8;
    localparam int c_OP_JMP     = 9;
    localparam int c_OP_JZ      = 10;
    localparam int c_OP_JC      = 11;
    localparam int c_OP_IN1     = 12;
    localparam int c_OP_OUT1    = 13;
    localparam int c_OP_NOP     = 14;
    localparam int c_OP_HALT    = 15;
    localparam int c_OP_ILLEGAL = 16;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_stop_pend;
    logic             w_stop_pend_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      w_op;
    logic             w_halt_now;

    // Instruction decode: purely combinational from ir, exactly one line set
    always_comb begin
        w_op = '0;
        case (ir[7:4])
            4'b1111: begin
                if (ir[3:2] == 2'b11 && ir[1:0] == 2'b11) w_op[c_OP_ILLEGAL] = 1'b1;
                else if (ir[3:2] == 2'b11)                w_op[c_OP_MOVC]    = 1'b1;
                else if (ir[1:0] == 2'b11)                w_op[c_OP_MOVB]    = 1'b1;
                else                                      w_op[c_OP_MOVA]    = 1'b1;
            end
            4'b1001: w_op[c_OP_ADD]  = 1'b1;
            4'b0110: w_op[c_OP_SUB]  = 1'b1;
            4'b1011: w_op[c_OP_AND1] = 1'b1;
            4'b0101: w_op[c_OP_NOT1] = 1'b1;
            4'b0010: w_op[c_OP_IN1]  = 1'b1;
            4'b0100: w_op[c_OP_OUT1] = 1'b1;
            4'b0111: w_op[c_OP_NOP]  = 1'b1;
            4'b1000: w_op[c_OP_HALT] = 1'b1;
            4'b1010: begin
                if (ir[1:0] == 2'b00)      w_op[c_OP_RSR]     = 1'b1;
                else if (ir[1:0] == 2'b11) w_op[c_OP_RSL]     = 1'b1;
                else                       w_op[c_OP_ILLEGAL] = 1'b1;
            end
            4'b0011: begin
                case (ir[3:0])
                    4'b0000: w_op[c_OP_JMP]     = 1'b1;
                    4'b0001: w_op[c_OP_JZ]      = 1'b1;
                    4'b0010: w_op[c_OP_JC]      = 1'b1;
                    default: w_op[c_OP_ILLEGAL] = 1'b1;
                endcase
            end
            default: w_op[c_OP_ILLEGAL] = 1'b1;
        endcase
    end

    // An illegal opcode only halts when the build asks for it; otherwise it retires as a nop
    assign w_halt_now = w_op[c_OP_HALT] | (HALT_ON_ILLEGAL & w_op[c_OP_ILLEGAL]);

    // Next-state and pending-stop logic
    always_comb begin
        w_state_nxt     = r_state;
        w_stop_pend_nxt = r_stop_pend;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_FETCH;
            end
            c_FETCH: begin
                w_state_nxt = c_EXEC;
                if (stop) w_stop_pend_nxt = 1'b1;
            end
            c_EXEC: begin
                if (w_halt_now)              w_state_nxt = c_HALTED;
                else if (r_stop_pend | stop) w_state_nxt = c_IDLE;
                else if (step_mode)          w_state_nxt = c_PAUSE;
                else                         w_state_nxt = c_FETCH;
                if (stop) w_stop_pend_nxt = 1'b1;
            end
            c_PAUSE: begin
                // stop outranks step when both arrive together
                if (r_stop_pend | stop)      w_state_nxt = c_IDLE;
                else if (step | !step_mode)  w_state_nxt = c_FETCH;
                if (stop) w_stop_pend_nxt = 1'b1;
            end
            c_HALTED: begin
                if (start) w_state_nxt = c_FETCH;
            end
            default: w_state_nxt = c_IDLE;
        endcase
        // A stop request is consumed whenever the sequencer comes to rest
        if (w_state_nxt == c_IDLE || w_state_nxt == c_HALTED) w_stop_pend_nxt = 1'b0;
    end

    // State register, pending stop and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_stop_pend <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            if (r_state == c_EXEC) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Status outputs decode straight from the state register so reset drops them at once
    assign sm        = (r_state == c_EXEC);
    assign cyc_valid = (r_state == c_FETCH) | (r_state == c_EXEC);
    assign running   = (r_state == c_FETCH) | (r_state == c_EXEC) | (r_state == c_PAUSE);
    assign halted    = (r_state == c_HALTED);
    assign state     = r_state;
    assign op        = w_op;
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire
